// File: rtl/rat_intc_pkg.sv
// rat_intc_pkg: shared types and default IO port ids for the RAT interrupt controller
package rat_intc_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} intc_state_t;
  localparam int ID_W = 3;
  localparam logic [7:0] MASK_PORT_D = 8'hF0;
  localparam logic [7:0] PEND_PORT_D = 8'hF1;
  localparam logic [7:0] STAT_PORT_D = 8'hF2;
  localparam logic [7:0] EOI_PORT_D  = 8'hF3;
endpackage

// File: rtl/rat_intc_prio_enc.sv
// rat_intc_prio_enc: lowest set index of eligible wins; source 0 is highest priority
module rat_intc_prio_enc
  import rat_intc_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] i_eligible,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id
);
  always_comb begin
    o_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (i_eligible[i]) o_id = ID_W'(i);
  end
  assign o_valid = |i_eligible;
endmodule

// File: rtl/rat_intr_ctrl.sv
// rat_intr_ctrl: latches, masks and prioritises IRQ edges, pulses INTR and holds
// the dispatched source in service until software writes end-of-interrupt.
module rat_intr_ctrl
  import rat_intc_pkg::*;
#(
  parameter int         N_SRC      = 8,
  parameter logic [7:0] MASK_PORT  = MASK_PORT_D,
  parameter logic [7:0] PEND_PORT  = PEND_PORT_D,
  parameter logic [7:0] STAT_PORT  = STAT_PORT_D,
  parameter logic [7:0] EOI_PORT   = EOI_PORT_D,
  parameter int         INTR_PULSE = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_SRC-1:0] i_irq,
  input  logic [7:0]       i_port_id,
  input  logic [7:0]       i_out_port,
  input  logic             i_io_strb,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_hit,
  output logic             o_intr,
  output logic             o_in_svc
);
  localparam int CNT_W = INTR_PULSE > 1 ? $clog2(INTR_PULSE) : 1;
  logic [N_SRC-1:0] r_irq_q, r_mask, r_pend, w_rise, w_elig, w_clr;
  logic             w_valid, w_wr_mask, w_eoi;
  logic [ID_W-1:0]  w_win, r_cur_id, w_cur_n;
  intc_state_t      r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_intr, w_intr_n, r_in_svc, w_svc_n;
  assign w_rise    = i_irq & ~r_irq_q;
  assign w_elig    = r_pend & r_mask;
  assign w_wr_mask = i_io_strb && i_port_id == MASK_PORT;
  assign w_eoi     = i_io_strb && i_port_id == EOI_PORT;
  rat_intc_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .i_eligible(w_elig),
    .o_valid   (w_valid),
    .o_id      (w_win)
  );
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cur_n   = r_cur_id;
    w_intr_n  = r_intr;
    w_svc_n   = r_in_svc;
    w_clr     = '0;
    case (r_state)
      IDLE: if (w_valid) begin
        w_cur_n   = w_win;
        w_cnt_n   = CNT_W'(INTR_PULSE - 1);
        w_intr_n  = 1'b1;
        w_svc_n   = 1'b1;
        w_state_n = ASSERT;
      end
      ASSERT: if (r_cnt == '0) begin
        w_intr_n  = 1'b0;
        w_state_n = SERVICE;
      end else w_cnt_n = r_cnt - 1'b1;
      SERVICE: if (w_eoi) begin
        w_clr     = N_SRC'(1) << r_cur_id;
        w_svc_n   = 1'b0;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // irq_q tracks the line even in reset so a level already high gives no edge
  always_ff @(posedge i_clk) begin
    r_irq_q <= i_irq;
    if (i_reset) begin
      r_mask   <= '0;
      r_pend   <= '0;
      r_cur_id <= '0;
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_intr   <= 1'b0;
      r_in_svc <= 1'b0;
    end else begin
      if (w_wr_mask) r_mask <= i_out_port[N_SRC-1:0];
      r_pend   <= (r_pend & ~w_clr) | w_rise;
      r_cur_id <= w_cur_n;
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_intr   <= w_intr_n;
      r_in_svc <= w_svc_n;
    end
  end
  assign o_rd_hit  = i_port_id == MASK_PORT || i_port_id == PEND_PORT || i_port_id == STAT_PORT;
  assign o_rd_data = i_port_id == MASK_PORT ? 8'(r_mask) :
                     i_port_id == PEND_PORT ? 8'(r_pend) :
                     i_port_id == STAT_PORT ? {r_in_svc, 4'b0, r_cur_id} : 8'h00;
  assign o_intr    = r_intr;
  assign o_in_svc  = r_in_svc;
endmodule

// File: tb/tb_rat_intr_ctrl.sv
// tb_rat_intr_ctrl: directed vector table plus hand sequences for the interrupt controller
module tb_rat_intr_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq = 8'h01, pid = 8'h00, dout = 8'h00;
  logic       strb = 1'b0;
  logic [7:0] rd_data;
  logic       rd_hit, intr, in_svc;
  int         n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0] irq, pid, dout;
    logic       strb;
    logic [7:0] rd;
    logic       hit, intr, svc;
  } vec_t;
  vec_t tbl[26];
  rat_intr_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_irq(irq), .i_port_id(pid), .i_out_port(dout),
    .i_io_strb(strb), .o_rd_data(rd_data), .o_rd_hit(rd_hit), .o_intr(intr), .o_in_svc(in_svc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // drive inputs, check pre-edge view (reads + registered outputs), then advance one edge
  task automatic vec(input string nm, input logic [7:0] v_irq, v_pid, v_dout, input logic v_strb,
                     input logic [7:0] e_rd, input logic e_hit, e_intr, e_svc);
    irq = v_irq; pid = v_pid; dout = v_dout; strb = v_strb;
    #1;
    chk({nm, ".rd"}, rd_data, e_rd);
    chk({nm, ".hit"}, 8'(rd_hit), 8'(e_hit));
    chk({nm, ".intr"}, 8'(intr), 8'(e_intr));
    chk({nm, ".svc"}, 8'(in_svc), 8'(e_svc));
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{8'h01, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{8'h01, 8'hF0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8'h01, 8'hF2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{8'h01, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h01, 8'hF3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h01, 8'hF0, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{8'h09, 8'hF0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{8'h09, 8'hF1, 8'h00, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{8'h09, 8'hF2, 8'h00, 1'b0, 8'h83, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{8'h09, 8'hF2, 8'h00, 1'b0, 8'h83, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{8'h09, 8'hF2, 8'h00, 1'b0, 8'h83, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{8'h09, 8'hF3, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{8'h09, 8'hF2, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{8'h09, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{8'h09, 8'hF0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{8'h29, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{8'h29, 8'hF1, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{8'h29, 8'hF1, 8'h00, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{8'h29, 8'hF0, 8'h20, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{8'h29, 8'hF2, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{8'h29, 8'hF2, 8'h00, 1'b0, 8'h85, 1'b1, 1'b1, 1'b1};
    tbl[21] = '{8'h29, 8'hF2, 8'h00, 1'b0, 8'h85, 1'b1, 1'b1, 1'b1};
    tbl[22] = '{8'h29, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[23] = '{8'h29, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{8'h29, 8'hF0, 8'hFF, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{8'h29, 8'hF0, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    pid = 8'hF1;
    #1;
    chk("reset.pend", rd_data, 8'h00);
    chk("reset.intr", 8'(intr), 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 26; i++)
      vec($sformatf("tbl%0d", i), tbl[i].irq, tbl[i].pid, tbl[i].dout, tbl[i].strb,
          tbl[i].rd, tbl[i].hit, tbl[i].intr, tbl[i].svc);
    // simultaneous rises: id 1 first, EOI during ASSERT ignored, then id 6
    vec("p0",  8'h00, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("p1",  8'h42, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("p2",  8'h42, 8'hF1, 8'h00, 1'b0, 8'h42, 1'b1, 1'b0, 1'b0);
    vec("p3",  8'h42, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    vec("p4",  8'h42, 8'hF1, 8'h00, 1'b0, 8'h42, 1'b1, 1'b1, 1'b1);
    vec("p5",  8'h42, 8'hF2, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1);
    vec("p6",  8'h42, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    vec("p7",  8'h42, 8'hF1, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
    vec("p8",  8'h42, 8'hF2, 8'h00, 1'b0, 8'h86, 1'b1, 1'b1, 1'b1);
    vec("p9",  8'h42, 8'hF2, 8'h00, 1'b0, 8'h86, 1'b1, 1'b1, 1'b1);
    vec("p10", 8'h42, 8'hF2, 8'h00, 1'b0, 8'h86, 1'b1, 1'b0, 1'b1);
    vec("p11", 8'h42, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    vec("p12", 8'h42, 8'hF2, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0);
    vec("p13", 8'h42, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    // rise of the serviced source in its EOI cycle keeps it pending
    vec("r0",  8'h00, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("r1",  8'h04, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("r2",  8'h04, 8'hF1, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0);
    vec("r3",  8'h00, 8'hF2, 8'h00, 1'b0, 8'h82, 1'b1, 1'b1, 1'b1);
    vec("r4",  8'h00, 8'hF2, 8'h00, 1'b0, 8'h82, 1'b1, 1'b1, 1'b1);
    vec("r5",  8'h00, 8'hF2, 8'h00, 1'b0, 8'h82, 1'b1, 1'b0, 1'b1);
    vec("r6",  8'h04, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    vec("r7",  8'h04, 8'hF1, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0);
    vec("r8",  8'h04, 8'hF2, 8'h00, 1'b0, 8'h82, 1'b1, 1'b1, 1'b1);
    vec("r9",  8'h04, 8'hF2, 8'h00, 1'b0, 8'h82, 1'b1, 1'b1, 1'b1);
    vec("r10", 8'h04, 8'hF1, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1);
    // reset while in SERVICE, then a spurious EOI
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec("x0",  8'h04, 8'hF0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("x1",  8'h04, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("x2",  8'h04, 8'hF3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    vec("x3",  8'h04, 8'hF2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("x4",  8'h04, 8'hF0, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("x5",  8'h04, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vec("x6",  8'h04, 8'hF2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
